// File: rtl/ethernet_frame_receiver.sv
// Ethernet frame receiver: a 4-byte delay line holds back the FCS while payload bytes
// stream to the owning receive slot and the CRC engine; each frame ends in a good/bad pulse.
module ethernet_frame_receiver #(
    parameter int unsigned SLOTS           = 2,
    parameter int unsigned MIN_FRAME_BYTES = 64,
    parameter int unsigned MAX_FRAME_BYTES = 1518,
    parameter int unsigned CRC_TIMEOUT     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [8:0]       data,
    input  logic             data_enable,
    output logic             data_ready,
    input  logic [SLOTS-1:0] slot_enable,
    output logic [7:0]       crc_data,
    output logic             crc_data_valid,
    output logic             crc_data_last,
    input  logic [31:0]      crc_result,
    input  logic             crc_result_valid,
    output logic [7:0]       packet_data,
    output logic [SLOTS-1:0] packet_data_valid,
    output logic [SLOTS-1:0] good_packet,
    output logic [SLOTS-1:0] bad_packet,
    output logic [15:0]      frame_length,
    output logic [2:0]       bad_reason,
    output logic [15:0]      drop_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FORWARD,
        S_WAIT_CRC,
        S_REPORT,
        S_DROP
    } state_t;

    localparam logic [15:0] MIN_LEN      = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] MAX_LEN      = 16'(MAX_FRAME_BYTES);
    localparam logic [15:0] TIMEOUT_LAST = 16'(CRC_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [3:0][7:0]   dly_q, dly_d;
    logic [2:0]        fill_q, fill_d;
    logic [15:0]       len_q, len_d;
    logic [31:0]       fcs_q, fcs_d;
    logic              crc_flag_q, crc_flag_d;
    logic              abort_q, abort_d;
    logic [SLOTS-1:0]  slot_q, slot_d;
    logic [15:0]       timer_q, timer_d;
    logic [15:0]       drop_q, drop_d;
    logic              ready_q, ready_d;
    logic [7:0]        out_data_q, out_data_d;
    logic [SLOTS-1:0]  pkt_valid_q, pkt_valid_d;
    logic              crc_valid_q, crc_valid_d;
    logic              crc_last_q, crc_last_d;
    logic [SLOTS-1:0]  good_q, good_d;
    logic [SLOTS-1:0]  bad_q, bad_d;
    logic [15:0]       flen_q, flen_d;
    logic [2:0]        reason_q, reason_d;

    logic              accept;
    logic              go_report;
    logic              runt_giant;
    logic [2:0]        reason;
    logic [SLOTS-1:0]  lowest_slot;

    assign lowest_slot = slot_enable & (~slot_enable + SLOTS'(1));

    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        fill_d      = fill_q;
        len_d       = len_q;
        fcs_d       = fcs_q;
        crc_flag_d  = crc_flag_q;
        abort_d     = abort_q;
        slot_d      = slot_q;
        timer_d     = timer_q;
        drop_d      = drop_q;
        out_data_d  = out_data_q;
        pkt_valid_d = '0;
        crc_valid_d = 1'b0;
        crc_last_d  = 1'b0;
        good_d      = '0;
        bad_d       = '0;
        flen_d      = '0;
        reason_d    = '0;
        go_report   = 1'b0;
        runt_giant  = 1'b0;
        reason      = '0;
        accept      = data_enable && ready_q;

        case (state_q)
            S_IDLE: begin
                if (accept && data[8]) begin
                    if (|slot_enable) begin
                        slot_d     = lowest_slot;
                        dly_d      = {24'h0, data[7:0]};
                        fill_d     = 3'd1;
                        len_d      = 16'd1;
                        crc_flag_d = 1'b0;
                        abort_d    = 1'b0;
                        state_d    = S_FORWARD;
                    end else begin
                        if (drop_q != '1) begin
                            drop_d = drop_q + 16'd1;
                        end
                        state_d = S_DROP;
                    end
                end
            end
            S_FORWARD: begin
                if (accept) begin
                    if (data[8]) begin
                        abort_d = 1'b1;
                    end
                    if (len_q != '1) begin
                        len_d = len_q + 16'd1;
                    end
                    dly_d = {dly_q[2:0], data[7:0]};
                    // Only the byte leaving a full delay line is payload; the last four are the FCS.
                    if (fill_q == 3'd4) begin
                        out_data_d  = dly_q[3];
                        pkt_valid_d = slot_q;
                        crc_valid_d = 1'b1;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end else begin
                    fcs_d   = {dly_q[0], dly_q[1], dly_q[2], dly_q[3]};
                    fill_d  = '0;
                    timer_d = '0;
                    if (len_q < 16'd5) begin
                        crc_flag_d = 1'b1;
                        go_report  = 1'b1;
                        state_d    = S_REPORT;
                    end else begin
                        crc_last_d = 1'b1;
                        state_d    = S_WAIT_CRC;
                    end
                end
            end
            S_WAIT_CRC: begin
                if (crc_result_valid) begin
                    if (crc_result != fcs_q) begin
                        crc_flag_d = 1'b1;
                    end
                    go_report = 1'b1;
                    state_d   = S_REPORT;
                end else if (timer_q == TIMEOUT_LAST) begin
                    crc_flag_d = 1'b1;
                    go_report  = 1'b1;
                    state_d    = S_REPORT;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            S_DROP: begin
                if (!data_enable) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Verdict is registered on entry so the pulse lines up with the single S_REPORT cycle.
        if (go_report) begin
            runt_giant = (len_q < MIN_LEN) || (len_q > MAX_LEN);
            reason     = {abort_q, runt_giant, crc_flag_d};
            flen_d     = len_q;
            if (reason == 3'b000) begin
                good_d = slot_q;
            end else begin
                bad_d    = slot_q;
                reason_d = reason;
            end
        end

        ready_d = (state_d == S_IDLE) || (state_d == S_FORWARD) || (state_d == S_DROP);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            dly_q       <= '0;
            fill_q      <= '0;
            len_q       <= '0;
            fcs_q       <= '0;
            crc_flag_q  <= 1'b0;
            abort_q     <= 1'b0;
            slot_q      <= '0;
            timer_q     <= '0;
            drop_q      <= '0;
            ready_q     <= 1'b0;
            out_data_q  <= '0;
            pkt_valid_q <= '0;
            crc_valid_q <= 1'b0;
            crc_last_q  <= 1'b0;
            good_q      <= '0;
            bad_q       <= '0;
            flen_q      <= '0;
            reason_q    <= '0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            fill_q      <= fill_d;
            len_q       <= len_d;
            fcs_q       <= fcs_d;
            crc_flag_q  <= crc_flag_d;
            abort_q     <= abort_d;
            slot_q      <= slot_d;
            timer_q     <= timer_d;
            drop_q      <= drop_d;
            ready_q     <= ready_d;
            out_data_q  <= out_data_d;
            pkt_valid_q <= pkt_valid_d;
            crc_valid_q <= crc_valid_d;
            crc_last_q  <= crc_last_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            flen_q      <= flen_d;
            reason_q    <= reason_d;
        end
    end

    assign data_ready        = ready_q;
    assign crc_data          = out_data_q;
    assign crc_data_valid    = crc_valid_q;
    assign crc_data_last     = crc_last_q;
    assign packet_data       = out_data_q;
    assign packet_data_valid = pkt_valid_q;
    assign good_packet       = good_q;
    assign bad_packet        = bad_q;
    assign frame_length      = flen_q;
    assign bad_reason        = reason_q;
    assign drop_count        = drop_q;

endmodule

// File: tb/tb_ethernet_frame_receiver.sv
// Directed bench for ethernet_frame_receiver: drives whole frames, answers as the CRC engine
// and checks forwarding, latency, verdicts, drops and reset recovery.
module tb_ethernet_frame_receiver;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  data = '0;
    logic        data_enable = 1'b0;
    logic        data_ready;
    logic [1:0]  slot_enable = 2'b01;
    logic [7:0]  crc_data;
    logic        crc_data_valid;
    logic        crc_data_last;
    logic [31:0] crc_result = '0;
    logic        crc_result_valid = 1'b0;
    logic [7:0]  packet_data;
    logic [1:0]  packet_data_valid;
    logic [1:0]  good_packet;
    logic [1:0]  bad_packet;
    logic [15:0] frame_length;
    logic [2:0]  bad_reason;
    logic [15:0] drop_count;

    ethernet_frame_receiver #(
        .SLOTS(2),
        .MIN_FRAME_BYTES(64),
        .MAX_FRAME_BYTES(1518),
        .CRC_TIMEOUT(16)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .data(data),
        .data_enable(data_enable),
        .data_ready(data_ready),
        .slot_enable(slot_enable),
        .crc_data(crc_data),
        .crc_data_valid(crc_data_valid),
        .crc_data_last(crc_data_last),
        .crc_result(crc_result),
        .crc_result_valid(crc_result_valid),
        .packet_data(packet_data),
        .packet_data_valid(packet_data_valid),
        .good_packet(good_packet),
        .bad_packet(bad_packet),
        .frame_length(frame_length),
        .bad_reason(bad_reason),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor, sampled on the falling edge.
    int         vld_cnt0 = 0, vld_cnt1 = 0, last_cnt = 0, last_cyc = 0;
    int         rep_cnt = 0, rep_cyc = 0, first_vld_cyc = 0, ready_low_cnt = 0;
    int         pair_err = 0, overlap_err = 0;
    logic [1:0] rep_good = '0, rep_bad = '0;
    logic [2:0] rep_reason = '0;
    logic [15:0] rep_len = '0;
    logic       prev_vld = 1'b0;
    logic [7:0] vq[$];

    always @(negedge clock) begin
        if (packet_data_valid[0]) vld_cnt0 <= vld_cnt0 + 1;
        if (packet_data_valid[1]) vld_cnt1 <= vld_cnt1 + 1;
        if (|packet_data_valid) vq.push_back(packet_data);
        if ((|packet_data_valid) && !prev_vld) first_vld_cyc <= cyc;
        prev_vld <= |packet_data_valid;
        if ((crc_data_valid != (|packet_data_valid)) ||
            (crc_data_valid && (crc_data != packet_data)) ||
            (packet_data_valid == 2'b11)) pair_err <= pair_err + 1;
        if ((crc_data_valid && crc_data_last) || (|(good_packet & bad_packet)))
            overlap_err <= overlap_err + 1;
        if (crc_data_last) begin
            last_cnt <= last_cnt + 1;
            last_cyc <= cyc;
        end
        if ((|good_packet) || (|bad_packet)) begin
            rep_cnt    <= rep_cnt + 1;
            rep_cyc    <= cyc;
            rep_good   <= good_packet;
            rep_bad    <= bad_packet;
            rep_reason <= bad_reason;
            rep_len    <= frame_length;
        end
        if (!data_ready) ready_low_cnt <= ready_low_cnt + 1;
    end

    // Results of the most recent run_frame.
    logic [7:0]  fr[2048];
    int          sof_cyc;
    int          r_reported, r_v0, r_v1, r_last, r_lat, r_l2r, r_byte_err;
    logic [1:0]  r_good, r_bad;
    logic [2:0]  r_reason;
    logic [15:0] r_len;

    // crc_mode: 0 returns the captured FCS, 1 returns a wrong value, 2 never answers.
    task automatic run_frame(input int len, input int abort_at, input int crc_mode, input int seed);
        int v0, v1, lc, rc, qs, n;
        logic [31:0] fcs;
        for (int i = 0; i < len; i++) fr[i] = 8'((i * 37 + seed) & 255);
        v0 = vld_cnt0; v1 = vld_cnt1; lc = last_cnt; rc = rep_cnt; qs = vq.size();
        for (int i = 0; i < len; i++) begin
            @(posedge clock); #1;
            data = {((i == 0) || (i == abort_at)), fr[i]};
            data_enable = 1'b1;
            if (i == 0) sof_cyc = cyc;
        end
        @(posedge clock); #1;
        data_enable = 1'b0;
        data = '0;
        fcs = 32'(fr[len-4]) | (32'(fr[len-3]) << 8) | (32'(fr[len-2]) << 16) | (32'(fr[len-1]) << 24);
        if (len >= 5) begin
            for (int t = 0; t < 12; t++) begin
                @(posedge clock);
                if (last_cnt != lc) break;
            end
        end
        if (crc_mode < 2) begin
            repeat (3) @(posedge clock);
            #1;
            crc_result = (crc_mode == 0) ? fcs : ~fcs;
            crc_result_valid = 1'b1;
            @(posedge clock); #1;
            crc_result_valid = 1'b0;
        end
        for (int t = 0; t < 60; t++) begin
            if (rep_cnt != rc) break;
            @(posedge clock);
        end
        #1;
        r_reported = rep_cnt - rc;
        r_good = rep_good; r_bad = rep_bad; r_reason = rep_reason; r_len = rep_len;
        r_v0 = vld_cnt0 - v0; r_v1 = vld_cnt1 - v1; r_last = last_cnt - lc;
        r_lat = first_vld_cyc - sof_cyc;
        r_l2r = rep_cyc - last_cyc;
        r_byte_err = 0;
        n = vq.size() - qs;
        for (int i = 0; i < n; i++) begin
            if ((i >= len - 4) || (vq[qs+i] != fr[i])) r_byte_err++;
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        data = 9'h1AA;
        data_enable = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset.data_ready got %b expected 0", data_ready); end
        checks++; if ({good_packet, bad_packet, packet_data_valid} !== 6'b0) begin errors++; $display("FAIL reset.pulses got %b expected 0", {good_packet, bad_packet, packet_data_valid}); end
        checks++; if ({crc_data_valid, crc_data_last, crc_data, packet_data} !== 18'b0) begin errors++; $display("FAIL reset.crc_out got %h expected 0", {crc_data_valid, crc_data_last, crc_data, packet_data}); end
        checks++; if ({drop_count, frame_length, bad_reason} !== 35'b0) begin errors++; $display("FAIL reset.counters got %h expected 0", {drop_count, frame_length, bad_reason}); end
        data_enable = 1'b0;
        data = '0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL reset.ready_after got %b expected 1", data_ready); end
    endtask

    task automatic test_good_frame();
        slot_enable = 2'b01;
        run_frame(64, -1, 0, 5);
        checks++; if (r_reported !== 1) begin errors++; $display("FAIL good.reported got %0d expected 1", r_reported); end
        checks++; if (r_good !== 2'b01 || r_bad !== 2'b00) begin errors++; $display("FAIL good.verdict got good=%b bad=%b expected good=01 bad=00", r_good, r_bad); end
        checks++; if (r_len !== 16'd64) begin errors++; $display("FAIL good.length got %0d expected 64", r_len); end
        checks++; if (r_v0 !== 60 || r_v1 !== 0) begin errors++; $display("FAIL good.bytes got %0d/%0d expected 60/0", r_v0, r_v1); end
        checks++; if (r_lat !== 5) begin errors++; $display("FAIL good.latency got %0d expected 5", r_lat); end
        checks++; if (r_byte_err !== 0) begin errors++; $display("FAIL good.payload got %0d bad bytes expected 0", r_byte_err); end
        checks++; if (r_last !== 1) begin errors++; $display("FAIL good.last got %0d expected 1", r_last); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL good.drop got %0d expected 0", drop_count); end
    endtask

    task automatic test_crc_mismatch();
        slot_enable = 2'b01;
        run_frame(64, -1, 1, 11);
        checks++; if (r_reported !== 1 || r_bad !== 2'b01 || r_good !== 2'b00) begin errors++; $display("FAIL crc_bad.verdict got rep=%0d good=%b bad=%b expected 1/00/01", r_reported, r_good, r_bad); end
        checks++; if (r_reason !== 3'b001) begin errors++; $display("FAIL crc_bad.reason got %b expected 001", r_reason); end
    endtask

    task automatic test_drop();
        int v, rc, rl, lc;
        slot_enable = 2'b00;
        v = vld_cnt0 + vld_cnt1; rc = rep_cnt; rl = ready_low_cnt; lc = last_cnt;
        for (int f = 0; f < 3; f++) run_frame(10, -1, 2, 20 + f);
        checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL drop.count got %0d expected 3", drop_count); end
        checks++; if ((vld_cnt0 + vld_cnt1 - v) !== 0 || (last_cnt - lc) !== 0) begin errors++; $display("FAIL drop.traffic got %0d bytes %0d lasts expected 0", vld_cnt0 + vld_cnt1 - v, last_cnt - lc); end
        checks++; if ((rep_cnt - rc) !== 0) begin errors++; $display("FAIL drop.reports got %0d expected 0", rep_cnt - rc); end
        checks++; if ((ready_low_cnt - rl) !== 0) begin errors++; $display("FAIL drop.ready got %0d low cycles expected 0", ready_low_cnt - rl); end
    endtask

    task automatic test_slot1_runt();
        slot_enable = 2'b10;
        run_frame(40, -1, 0, 33);
        checks++; if (r_v1 !== 36 || r_v0 !== 0) begin errors++; $display("FAIL runt.bytes got %0d/%0d expected 0/36", r_v0, r_v1); end
        checks++; if (r_bad !== 2'b10 || r_good !== 2'b00) begin errors++; $display("FAIL runt.verdict got good=%b bad=%b expected 00/10", r_good, r_bad); end
        checks++; if (r_reason !== 3'b010 || r_len !== 16'd40) begin errors++; $display("FAIL runt.reason got %b len %0d expected 010 len 40", r_reason, r_len); end
        checks++; if (r_byte_err !== 0) begin errors++; $display("FAIL runt.payload got %0d bad bytes expected 0", r_byte_err); end
    endtask

    task automatic test_abort_timeout();
        slot_enable = 2'b01;
        run_frame(100, 49, 2, 44);
        checks++; if (r_reported !== 1 || r_bad !== 2'b01) begin errors++; $display("FAIL abort.verdict got rep=%0d bad=%b expected 1/01", r_reported, r_bad); end
        checks++; if (r_reason !== 3'b101 || r_len !== 16'd100) begin errors++; $display("FAIL abort.reason got %b len %0d expected 101 len 100", r_reason, r_len); end
        checks++; if (r_l2r !== 16) begin errors++; $display("FAIL abort.timeout got %0d cycles expected 16", r_l2r); end
        checks++; if (r_v0 !== 96 || r_byte_err !== 0) begin errors++; $display("FAIL abort.bytes got %0d (%0d bad) expected 96 (0 bad)", r_v0, r_byte_err); end
    endtask

    task automatic test_short_frame();
        slot_enable = 2'b01;
        run_frame(3, -1, 2, 55);
        checks++; if (r_bad !== 2'b01 || r_reason !== 3'b011 || r_len !== 16'd3) begin errors++; $display("FAIL short.verdict got bad=%b reason=%b len=%0d expected 01/011/3", r_bad, r_reason, r_len); end
        checks++; if (r_last !== 0 || r_v0 !== 0) begin errors++; $display("FAIL short.traffic got %0d lasts %0d bytes expected 0/0", r_last, r_v0); end
    endtask

    task automatic test_giant();
        slot_enable = 2'b01;
        run_frame(1519, -1, 0, 66);
        checks++; if (r_bad !== 2'b01 || r_reason !== 3'b010 || r_len !== 16'd1519) begin errors++; $display("FAIL giant.verdict got bad=%b reason=%b len=%0d expected 01/010/1519", r_bad, r_reason, r_len); end
        checks++; if (r_v0 !== 1515 || r_byte_err !== 0) begin errors++; $display("FAIL giant.bytes got %0d (%0d bad) expected 1515 (0 bad)", r_v0, r_byte_err); end
    endtask

    task automatic test_reset_midframe();
        int v, rc, lc;
        slot_enable = 2'b01;
        v = 0; rc = 0; lc = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            data = {(i == 0), 8'((i * 13 + 7) & 255)};
            data_enable = 1'b1;
            if (i == 30) reset_n = 1'b0;
            if (i == 31) begin
                reset_n = 1'b1;
                v = vld_cnt0 + vld_cnt1; rc = rep_cnt; lc = last_cnt;
            end
        end
        @(posedge clock); #1;
        data_enable = 1'b0;
        data = '0;
        repeat (30) @(posedge clock);
        #1;
        checks++; if ((vld_cnt0 + vld_cnt1 - v) !== 0 || (last_cnt - lc) !== 0 || (rep_cnt - rc) !== 0) begin errors++; $display("FAIL rst_mid.quiet got %0d bytes %0d lasts %0d reports expected 0", vld_cnt0 + vld_cnt1 - v, last_cnt - lc, rep_cnt - rc); end
        run_frame(64, -1, 0, 77);
        checks++; if (r_good !== 2'b01 || r_bad !== 2'b00 || r_len !== 16'd64) begin errors++; $display("FAIL rst_mid.recover got good=%b bad=%b len=%0d expected 01/00/64", r_good, r_bad, r_len); end
        checks++; if (r_v0 !== 60 || r_byte_err !== 0) begin errors++; $display("FAIL rst_mid.bytes got %0d (%0d bad) expected 60 (0 bad)", r_v0, r_byte_err); end
    endtask

    task automatic test_invariants();
        checks++; if (pair_err !== 0) begin errors++; $display("FAIL inv.crc_pkt_pair got %0d expected 0", pair_err); end
        checks++; if (overlap_err !== 0) begin errors++; $display("FAIL inv.overlap got %0d expected 0", overlap_err); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_crc_mismatch();
        test_drop();
        test_slot1_runt();
        test_abort_timeout();
        test_short_frame();
        test_giant();
        test_reset_midframe();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ethernet_frame_receiver.md
Name: ethernet_frame_receiver

Overview:
- Receives a byte stream from the MAC front end, with bit 8 set as the start-of-frame (SOF) marker.
- Strips the trailing 4-byte FCS. Forwards the remaining bytes to one of SLOTS receive-queue slots and streams them to an external CRC-32 engine.
- At end of frame, compares the CRC result with the captured FCS, checks length limits, and pulses good/bad for the owning slot.
- Frames with no free slot are dropped and counted.

Parameters:
- SLOTS, 2, number of receive-queue slots (≥1).
- MIN_FRAME_BYTES, 64, minimum legal length including FCS.
- MAX_FRAME_BYTES, 1518, maximum legal length including FCS.
- CRC_TIMEOUT, 16, cycles to wait for crc_result_valid before declaring the frame bad.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  reset, synchronous, active-low.
- data  input  9  [7:0] byte, [8] SOF marker.
- data_enable  input  1  byte valid; bytes of a frame are contiguous; a low level ends the frame.
- data_ready  output  1  block accepts input bytes.
- slot_enable  input  SLOTS  slot j has space for a new frame.
- crc_data  output  8  byte to the CRC engine.
- crc_data_valid  output  1  crc_data valid.
- crc_data_last  output  1  one-cycle end-of-frame pulse (crc_data_valid is low in that cycle).
- crc_result  input  32  CRC of the bytes sent.
- crc_result_valid  input  1  crc_result valid.
- packet_data  output  8  forwarded payload byte.
- packet_data_valid  output  SLOTS  one-hot, marks the owning slot.
- good_packet  output  SLOTS  one-cycle pulse: frame passed all checks.
- bad_packet  output  SLOTS  one-cycle pulse: frame failed a check.
- frame_length  output  16  total bytes including FCS; valid while good_packet or bad_packet is high.
- bad_reason  output  3  valid with bad_packet: [0] CRC mismatch or timeout, [1] runt or giant, [2] aborted by mid-frame SOF.
- drop_count  output  16  frames dropped for lack of a slot; saturates at 0xFFFF.

Behaviour:
- Reset: every output is 0. State is S_IDLE, and the 4-stage delay line, length counter, FCS register, flags and drop_count are all cleared.
- Reset mid-frame: the rest of that frame is ignored until the next SOF.
- data_ready is 1 in S_IDLE, S_FORWARD and S_DROP, and 0 in S_WAIT_CRC and S_REPORT. Bytes presented while data_ready=0 are discarded.
- Delay line: each accepted byte shifts into stage 0. A byte is forwarded only once 4 newer bytes of the same frame have been accepted, so the FCS is never forwarded.
- Latency: packet_data and crc_data for byte k are registered in the cycle after byte k+4 is accepted, so a contiguous stream sees 5 cycles of latency. Both outputs carry identical bytes and valids.
- S_IDLE:
  - Bytes without SOF are ignored.
  - On SOF, latch the lowest index j with slot_enable[j]=1 as a one-hot slot register, clear the length counter to 1, and go to S_FORWARD.
  - If no slot is enabled, increment drop_count (saturating) and go to S_DROP.
- S_FORWARD:
  - Count bytes; the counter saturates at 0xFFFF.
  - When data_enable falls, pulse crc_data_last in the next cycle.
  - Capture the FCS as {d0,d1,d2,d3}, where d3 is the oldest delay-line stage and is the first FCS byte (LSB).
  - If length < 5, no bytes were sent to the CRC engine: suppress crc_data_last and go directly to S_REPORT with the CRC flag set.
  - Otherwise go to S_WAIT_CRC.
  - An SOF seen mid-frame does not restart the frame: it sets the abort flag and the byte is treated as data.
  - slot_enable changes are ignored until S_IDLE.
- S_WAIT_CRC:
  - On crc_result_valid, set the CRC flag if crc_result ≠ FCS, then go to S_REPORT.
  - If CRC_TIMEOUT cycles pass without crc_result_valid, set the CRC flag and go to S_REPORT.
  - crc_result_valid outside S_WAIT_CRC is ignored.
- S_REPORT: lasts exactly one cycle, then goes to S_IDLE.
  - The runt/giant flag is set if length < MIN_FRAME_BYTES or length > MAX_FRAME_BYTES.
  - If no flag is set, pulse good_packet[slot]; otherwise pulse bad_packet[slot] with bad_reason.
  - frame_length is driven in the same cycle.
- Giant frames keep forwarding every byte; they are flagged only at report time.
- S_DROP: nothing is forwarded and no CRC traffic is issued. Return to S_IDLE when data_enable=0.
- good_packet and bad_packet are never high in the same cycle.

Test Plan:
- Slot 0 enabled, 64-byte frame with correct FCS, contiguous, CRC returns a match after 3 cycles:
  - 60 bytes appear on packet_data_valid[0]; the first is 5 cycles after SOF.
  - crc_data_last pulses once.
  - good_packet=01, frame_length=64.
- Same frame with crc_result ≠ FCS -> bad_packet=01, bad_reason=001.
- slot_enable=00, three frames -> no valid output on any slot, drop_count=3, data_ready stays high.
- slot_enable=10, 40-byte frame with a matching CRC -> traffic only on slot 1, bad_packet=10, bad_reason=010, frame_length=40.
- 100-byte frame with SOF asserted again at byte 50, CRC never returns -> after 16 cycles, bad_packet asserts with bad_reason=101 and frame_length=100.
- Reset asserted at byte 30 of a frame, then 20 bytes without SOF, then a valid 64-byte frame -> no output before the new SOF; the new frame reports good_packet.
